hydra_switch: RTL and testbench

//  4-port input-buffered packet switch. Each ingress port stores whole packets in its own word FIFO.
//  Per-egress arbiters grant head-of-line packets to the egress named in the packet's control word.
//  Top-level switching core; the upstream source sends framed packets, the downstream sink grants
//  one packet at a time via ready pulses.

---
 rtl/hydra_switch.sv | 279 +++++++++++++++++++++++++++
 tb/tb_hydra_switch.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hydra_switch.sv
// hydra_switch: 4-port input-buffered packet switch with per-egress credit-driven arbitration.
// Build option HYDRA_CUT_THROUGH_EN enables cut-through eligibility in match_mode 2/3.
module hydra_switch #(
   parameter int unsigned DEPTH         = 1024,
   parameter int unsigned MAX_PKT_WORDS = 129
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       wr_sop,
   input  logic [3:0]       wr_eop,
   input  logic [3:0]       wr_vld,
   input  logic [3:0][15:0] wr_data,
   input  logic [3:0]       wrr_enable,
   input  logic [4:0]       match_threshold,
   input  logic [1:0]       match_mode,
   output logic [3:0]       pause,
   output logic             full,
   output logic             almost_full,
   input  logic [3:0]       ready,
   output logic [3:0]       rd_sop,
   output logic [3:0]       rd_eop,
   output logic [3:0]       rd_vld,
   output logic [3:0][15:0] rd_data
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] DepthC = CW'(DEPTH);
   localparam logic [CW-1:0] MaxC   = CW'(MAX_PKT_WORDS);
   localparam logic [CW-1:0] Max2C  = CW'(2 * MAX_PKT_WORDS);

   typedef enum logic [1:0] {InIdle, InRecv, InDrop} in_st_e;
   typedef enum logic [1:0] {EgIdle, EgData, EgEop} eg_st_e;

   // Entry = {last, data}
   logic [16:0]   mem_q [4][DEPTH];

   in_st_e        in_st_q [4], in_st_d [4];
   logic [15:0]   pend_q [4], pend_d [4];
   logic [3:0]    pend_vld_q, pend_vld_d;
   logic [AW-1:0] wptr_q [4], wptr_d [4];
   logic [AW-1:0] rptr_q [4], rptr_d [4];
   logic [CW-1:0] cnt_q [4], cnt_d [4];
   logic [CW-1:0] pkt_q [4], pkt_d [4];

   eg_st_e        eg_st_q [4], eg_st_d [4];
   logic [1:0]    src_q [4], src_d [4];
   logic [1:0]    rr_q [4], rr_d [4];
   logic [3:0]    credit_q, credit_d;
   logic [3:0]    rd_sop_q, rd_sop_d;
   logic [3:0]    rd_eop_q, rd_eop_d;
   logic [3:0]    rd_vld_q, rd_vld_d;
   logic [3:0][15:0] rd_data_q, rd_data_d;
   logic [3:0]    pause_q, pause_d;
   logic          full_q, full_d;
   logic          af_q, af_d;

   logic [3:0]    push, wr_en, pkt_inc, pop, pkt_dec, bound, elig;
   logic [16:0]   push_word [4];
   logic [16:0]   head [4];
   logic [CW-1:0] free [4];
   logic [CW-1:0] free_nxt [4];

   function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] start);
      logic [1:0] idx;
      pick = start;
      // Scan from farthest to nearest offset so the nearest request wins.
      for (int k = 3; k >= 0; k--) begin
         idx = start + 2'(k);
         if (req[idx]) pick = idx;
      end
   endfunction

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         head[i] = mem_q[i][rptr_q[i]];
         free[i] = DepthC - cnt_q[i];
      end
   end

`ifdef HYDRA_CUT_THROUGH_EN
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         elig[i] = (pkt_q[i] != '0) ||
                   (match_mode[1] && (cnt_q[i] != '0) && (cnt_q[i] >= CW'(match_threshold)));
      end
   end
`else
   logic unused_thr;
   assign unused_thr = ^match_threshold;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         elig[i] = (pkt_q[i] != '0);
      end
   end
`endif

   // Ingress: the newest word is held back until eop so it can be stored with last=1.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         in_st_d[i]    = in_st_q[i];
         pend_d[i]     = pend_q[i];
         pend_vld_d[i] = pend_vld_q[i];
         push[i]       = 1'b0;
         push_word[i]  = '0;
         pkt_inc[i]    = 1'b0;
         unique case (in_st_q[i])
            InIdle: begin
               if (wr_sop[i]) begin
                  pend_vld_d[i] = 1'b0;
                  in_st_d[i]    = (free[i] < MaxC) ? InDrop : InRecv;
               end
            end
            InRecv: begin
               if (wr_eop[i]) begin
                  in_st_d[i]    = InIdle;
                  pend_vld_d[i] = 1'b0;
                  if (pend_vld_q[i]) begin
                     push[i]      = 1'b1;
                     push_word[i] = {1'b1, pend_q[i]};
                     pkt_inc[i]   = 1'b1;
                  end
               end else if (wr_vld[i]) begin
                  if (pend_vld_q[i]) begin
                     push[i]      = 1'b1;
                     push_word[i] = {1'b0, pend_q[i]};
                  end
                  pend_d[i]     = wr_data[i];
                  pend_vld_d[i] = 1'b1;
               end
            end
            InDrop: begin
               if (wr_eop[i]) in_st_d[i] = InIdle;
            end
            default: in_st_d[i] = InIdle;
         endcase
         wr_en[i] = push[i] && (free[i] != '0);
      end
   end

   // Egress arbitration and streaming.
   always_comb begin
      logic [3:0] req;
      logic [3:0] cand;
      logic [2:0] maxp;
      logic [1:0] win;
      pop     = '0;
      pkt_dec = '0;
      bound   = '0;
      for (int o = 0; o < 4; o++) begin
         if (eg_st_q[o] != EgIdle) bound[src_q[o]] = 1'b1;
      end
      for (int o = 0; o < 4; o++) begin
         eg_st_d[o]   = eg_st_q[o];
         src_d[o]     = src_q[o];
         rr_d[o]      = rr_q[o];
         credit_d[o]  = credit_q[o] | ready[o];
         rd_sop_d[o]  = 1'b0;
         rd_eop_d[o]  = 1'b0;
         rd_vld_d[o]  = 1'b0;
         rd_data_d[o] = '0;
         req  = '0;
         maxp = '0;
         for (int i = 0; i < 4; i++) begin
            req[i] = credit_q[o] && elig[i] && !bound[i] && (head[i][1:0] == 2'(o));
            if (req[i] && (head[i][6:4] > maxp)) maxp = head[i][6:4];
         end
         cand = req;
         if (wrr_enable[o]) begin
            for (int i = 0; i < 4; i++) begin
               if (head[i][6:4] != maxp) cand[i] = 1'b0;
            end
         end
         win = pick(cand, (match_mode == 2'd0) ? 2'd0 : rr_q[o]);
         unique case (eg_st_q[o])
            EgIdle: begin
               if (cand != '0) begin
                  eg_st_d[o]  = EgData;
                  src_d[o]    = win;
                  rr_d[o]     = win + 2'd1;
                  credit_d[o] = 1'b0;
                  rd_sop_d[o] = 1'b1;
               end
            end
            EgData: begin
               if (cnt_q[src_q[o]] != '0) begin
                  pop[src_q[o]] = 1'b1;
                  rd_vld_d[o]   = 1'b1;
                  rd_data_d[o]  = head[src_q[o]][15:0];
                  if (head[src_q[o]][16]) eg_st_d[o] = EgEop;
               end
            end
            EgEop: begin
               rd_eop_d[o]       = 1'b1;
               pkt_dec[src_q[o]] = 1'b1;
               eg_st_d[o]        = EgIdle;
            end
            default: eg_st_d[o] = EgIdle;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         wptr_d[i]   = wptr_q[i] + AW'(wr_en[i]);
         rptr_d[i]   = rptr_q[i] + AW'(pop[i]);
         cnt_d[i]    = cnt_q[i] + CW'(wr_en[i]) - CW'(pop[i]);
         pkt_d[i]    = pkt_q[i] + CW'(pkt_inc[i] & wr_en[i]) - CW'(pkt_dec[i]);
         free_nxt[i] = DepthC - cnt_d[i];
      end
      full_d = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pause_d[i] = free_nxt[i] < Max2C;
         if (free_nxt[i] < MaxC) full_d = 1'b1;
      end
      af_d = |pause_d;
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (wr_en[i]) mem_q[i][wptr_q[i]] <= push_word[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            in_st_q[i] <= InIdle;
            pend_q[i]  <= '0;
            wptr_q[i]  <= '0;
            rptr_q[i]  <= '0;
            cnt_q[i]   <= '0;
            pkt_q[i]   <= '0;
            eg_st_q[i] <= EgIdle;
            src_q[i]   <= '0;
            rr_q[i]    <= '0;
         end
         pend_vld_q <= '0;
         credit_q   <= '0;
         rd_sop_q   <= '0;
         rd_eop_q   <= '0;
         rd_vld_q   <= '0;
         rd_data_q  <= '0;
         pause_q    <= '0;
         full_q     <= 1'b0;
         af_q       <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            in_st_q[i] <= in_st_d[i];
            pend_q[i]  <= pend_d[i];
            wptr_q[i]  <= wptr_d[i];
            rptr_q[i]  <= rptr_d[i];
            cnt_q[i]   <= cnt_d[i];
            pkt_q[i]   <= pkt_d[i];
            eg_st_q[i] <= eg_st_d[i];
            src_q[i]   <= src_d[i];
            rr_q[i]    <= rr_d[i];
         end
         pend_vld_q <= pend_vld_d;
         credit_q   <= credit_d;
         rd_sop_q   <= rd_sop_d;
         rd_eop_q   <= rd_eop_d;
         rd_vld_q   <= rd_vld_d;
         rd_data_q  <= rd_data_d;
         pause_q    <= pause_d;
         full_q     <= full_d;
         af_q       <= af_d;
      end
   end

   assign rd_sop      = rd_sop_q;
   assign rd_eop      = rd_eop_q;
   assign rd_vld      = rd_vld_q;
   assign rd_data     = rd_data_q;
   assign pause       = pause_q;
   assign full        = full_q;
   assign almost_full = af_q;

endmodule

// File: tb/tb_hydra_switch.sv
// tb_hydra_switch: directed bench for hydra_switch; a single-packet vector table followed by
// arbitration, fill/drop and cut-through sequences, all checked against hand-computed values.
module tb_hydra_switch;
   logic             clk = 1'b0;
   logic             rst_n;
   logic [3:0]       wr_sop, wr_eop, wr_vld;
   logic [3:0][15:0] wr_data;
   logic [3:0]       wrr_enable;
   logic [4:0]       match_threshold;
   logic [1:0]       match_mode;
   logic [3:0]       pause;
   logic             full, almost_full;
   logic [3:0]       ready;
   logic [3:0]       rd_sop, rd_eop, rd_vld;
   logic [3:0][15:0] rd_data;

   always #5 clk = ~clk;

   hydra_switch dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .wr_sop          (wr_sop),
      .wr_eop          (wr_eop),
      .wr_vld          (wr_vld),
      .wr_data         (wr_data),
      .wrr_enable      (wrr_enable),
      .match_threshold (match_threshold),
      .match_mode      (match_mode),
      .pause           (pause),
      .full            (full),
      .almost_full     (almost_full),
      .ready           (ready),
      .rd_sop          (rd_sop),
      .rd_eop          (rd_eop),
      .rd_vld          (rd_vld),
      .rd_data         (rd_data)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Egress monitor: per-port capture of the current packet and a log of finished packets.
   logic [15:0] rx_buf [4][256];
   int          rx_len [4];
   int          sop_cyc [4];
   int          eop_cyc [4];
   int          sop_tot [4];
   int          eop_tot [4];
   logic [15:0] log_tag [4][16];
   int          log_len [4][16];
   int          log_n [4];

   always @(negedge clk) begin
      if (!rst_n) begin
         for (int o = 0; o < 4; o++) begin
            rx_len[o]  <= 0;
            sop_cyc[o] <= 0;
            eop_cyc[o] <= 0;
            sop_tot[o] <= 0;
            eop_tot[o] <= 0;
            log_n[o]   <= 0;
         end
      end else begin
         for (int o = 0; o < 4; o++) begin
            if (rd_sop[o]) begin
               sop_cyc[o] <= cyc;
               sop_tot[o] <= sop_tot[o] + 1;
               rx_len[o]  <= 0;
            end
            if (rd_vld[o]) begin
               if (rx_len[o] < 256) rx_buf[o][rx_len[o]] <= rd_data[o];
               rx_len[o] <= rx_len[o] + 1;
            end
            if (rd_eop[o]) begin
               eop_cyc[o] <= cyc;
               eop_tot[o] <= eop_tot[o] + 1;
               if (log_n[o] < 16) begin
                  log_tag[o][log_n[o]] <= (rx_len[o] > 1) ? rx_buf[o][1] : rx_buf[o][0];
                  log_len[o][log_n[o]] <= rx_len[o];
               end
               log_n[o] <= log_n[o] + 1;
            end
         end
      end
   end

   int n_chk  = 0;
   int n_fail = 0;
   int rdy_cyc;
   int eop_drv_cyc;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [15:0] dword(input int p, input int j);
      return 16'((p + 1) * 4096 + j);
   endfunction

   task automatic do_reset();
      rst_n  = 1'b0;
      wr_sop = '0;
      wr_eop = '0;
      wr_vld = '0;
      wr_data = '0;
      ready  = '0;
      repeat (10) step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic send_pkt(input int p, input logic [15:0] ctrl, input int ndata);
      step();
      wr_sop[p] = 1'b1;
      step();
      wr_sop[p]  = 1'b0;
      wr_vld[p]  = 1'b1;
      wr_data[p] = ctrl;
      for (int j = 0; j < ndata; j++) begin
         step();
         wr_data[p] = dword(p, j);
      end
      step();
      wr_vld[p]   = 1'b0;
      wr_eop[p]   = 1'b1;
      eop_drv_cyc = cyc;
      step();
      wr_eop[p] = 1'b0;
   endtask

   task automatic pulse_ready(input logic [3:0] mask);
      step();
      ready   = mask;
      rdy_cyc = cyc;
      step();
      ready = '0;
   endtask

   task automatic wait_eop(input int o, input int target, input int budget);
      int t = 0;
      while (eop_tot[o] < target && t < budget) begin
         step();
         t++;
      end
      chk($sformatf("eop_count_egress%0d", o), eop_tot[o], target);
   endtask

   typedef struct {
      int         port;
      logic [15:0] ctrl;
      int         ndata;
      logic [3:0] rdy;
      int         egress;
   } vec_t;

   vec_t vecs [5];

   task automatic run_order(input logic [1:0] mode);
      do_reset();
      match_mode = mode;
      for (int p = 0; p < 4; p++) send_pkt(p, 16'h0201, 4);
      for (int k = 0; k < 4; k++) begin
         pulse_ready(4'b0010);
         wait_eop(1, k + 1, 100);
      end
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("order_m%0d_slot%0d", mode, k), log_tag[1][k], dword(k, 0));
      end
   endtask

   task automatic run_rr(input logic [1:0] mode);
      logic [15:0] exp [3];
      do_reset();
      match_mode = mode;
      send_pkt(0, 16'h0101, 2);
      send_pkt(1, 16'h0101, 2);
      pulse_ready(4'b0010);
      wait_eop(1, 1, 100);
      send_pkt(0, 16'h0101, 2);
      pulse_ready(4'b0010);
      wait_eop(1, 2, 100);
      pulse_ready(4'b0010);
      wait_eop(1, 3, 100);
      exp[0] = dword(0, 0);
      exp[1] = (mode == 2'd0) ? dword(0, 0) : dword(1, 0);
      exp[2] = (mode == 2'd0) ? dword(1, 0) : dword(0, 0);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rr_m%0d_slot%0d", mode, k), log_tag[1][k], exp[k]);
      end
   endtask

   initial begin
      int eg, others0, others1, nd;
      vecs[0] = '{0, 16'h1002, 32, 4'b0100, 2};
      vecs[1] = '{1, 16'h0090, 1, 4'b0001, 0};
      vecs[2] = '{3, 16'h000D, 0, 4'b0010, 1};
      vecs[3] = '{2, 16'h4073, 128, 4'b1000, 3};
      vecs[4] = '{1, 16'h0A26, 20, 4'b0100, 2};

      wrr_enable      = '0;
      match_threshold = 5'd0;
      match_mode      = 2'd1;
      do_reset();

      rst_n = 1'b0;
      repeat (10) step();
      chk("reset_rd_sop", rd_sop, 0);
      chk("reset_rd_eop", rd_eop, 0);
      chk("reset_rd_vld", rd_vld, 0);
      chk("reset_rd_data", int'(rd_data[0] | rd_data[1] | rd_data[2] | rd_data[3]), 0);
      chk("reset_pause", pause, 0);
      chk("reset_full", full, 0);
      chk("reset_almost_full", almost_full, 0);
      rst_n = 1'b1;
      step();

      for (int v = 0; v < 5; v++) begin
         eg = vecs[v].egress;
         nd = vecs[v].ndata;
         others0 = 0;
         for (int o = 0; o < 4; o++) if (o != eg) others0 += sop_tot[o];
         send_pkt(vecs[v].port, vecs[v].ctrl, nd);
         pulse_ready(vecs[v].rdy);
         wait_eop(eg, eop_tot[eg] + 1, nd + 30);
         others1 = 0;
         for (int o = 0; o < 4; o++) if (o != eg) others1 += sop_tot[o];
         chk($sformatf("v%0d_sop_latency", v), sop_cyc[eg] - rdy_cyc, 2);
         chk($sformatf("v%0d_word_count", v), rx_len[eg], nd + 1);
         chk($sformatf("v%0d_ctrl_word", v), rx_buf[eg][0], vecs[v].ctrl);
         chk($sformatf("v%0d_last_word", v), rx_buf[eg][nd],
             (nd == 0) ? vecs[v].ctrl : dword(vecs[v].port, nd - 1));
         chk($sformatf("v%0d_eop_spacing", v), eop_cyc[eg] - sop_cyc[eg], nd + 2);
         chk($sformatf("v%0d_other_egress_sop", v), others1, others0);
      end

      run_order(2'd1);
      run_order(2'd0);
      run_rr(2'd1);
      run_rr(2'd0);

      // Weighted priority on egress 3: prio 6 from port 2 beats prio 2 from port 1.
      do_reset();
      match_mode = 2'd0;
      wrr_enable = 4'b1000;
      send_pkt(1, 16'h0223, 4);
      send_pkt(2, 16'h0263, 4);
      pulse_ready(4'b1000);
      wait_eop(3, 1, 100);
      pulse_ready(4'b1000);
      wait_eop(3, 2, 100);
      chk("wrr_first", log_tag[3][0], dword(2, 0));
      chk("wrr_second", log_tag[3][1], dword(1, 0));
      wrr_enable = '0;

      // Fill port 0 with maximum packets: 7 fit, the 8th is dropped.
      do_reset();
      for (int k = 0; k < 8; k++) begin
         send_pkt(0, 16'h4000, 128);
         step();
         if (k == 4) begin
            chk("fill5_pause0", pause[0], 0);
            chk("fill5_full", full, 0);
         end
         if (k == 5) begin
            chk("fill6_pause0", pause[0], 1);
            chk("fill6_almost_full", almost_full, 1);
            chk("fill6_full", full, 0);
         end
         if (k == 6) begin
            chk("fill7_full", full, 1);
            chk("fill7_pause", pause, 4'b0001);
         end
      end
      for (int k = 0; k < 7; k++) begin
         pulse_ready(4'b0001);
         wait_eop(0, k + 1, 300);
         chk($sformatf("drain_len%0d", k), log_len[0][k], 129);
      end
      pulse_ready(4'b0001);
      repeat (30) step();
      chk("dropped_pkt_not_sent", sop_tot[0], 7);
      chk("drain_pause", pause, 0);
      chk("drain_full", full, 0);
      chk("drain_almost_full", almost_full, 0);

      // Credit preset, then a 100-word packet in mode 2 with threshold 30.
      do_reset();
      match_mode      = 2'd2;
      match_threshold = 5'd30;
      pulse_ready(4'b0001);
      send_pkt(2, 16'h3180, 99);
      wait_eop(0, 1, 200);
`ifdef HYDRA_CUT_THROUGH_EN
      chk("ct_sop_before_wr_eop", int'(sop_cyc[0] < eop_drv_cyc), 1);
`else
      chk("sf_sop_after_wr_eop", sop_cyc[0] - eop_drv_cyc, 2);
`endif
      chk("ct_word_count", rx_len[0], 100);
      chk("ct_ctrl_word", rx_buf[0][0], 16'h3180);
      chk("ct_last_word", rx_buf[0][99], dword(2, 98));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
